// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754 single-format multiplier with a radix-2 shift-add mantissa array,
// followed by normalize, round-to-nearest-even and pack stages, plus full special-case and range-flag handling.
module fp_mul_seq #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic [DATA_W-1:0] res
);
    localparam int MAN_W  = DATA_W - EXP_W;
    localparam int FRAC_W = MAN_W - 1;
    localparam int CNT_W  = $clog2(MAN_W);
    localparam logic [EXP_W+1:0] BIAS_X = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic [EXP_W+1:0] EMAX_X = (EXP_W+2)'(2**EXP_W - 1);
    localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_FIN} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t              state_q;
    special_t            sp_q, sp_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q, done_q, ovf_q, unf_q, exc_q;
    logic [DATA_W-1:0]   res_q;
    logic                sign_q, exp_inc_q, g_q, r_q, s_q;
    logic [EXP_W-1:0]    ea_q, eb_q;
    logic [MAN_W-1:0]    ma_q, man_q;
    logic [2*MAN_W-1:0]  acc_q, acc_d, pn;
    logic [MAN_W:0]      add_d, man_rnd;
    logic [EXP_W+1:0]    e_q, e_d;
    logic                rnd_up, ovf_w, unf_w;
    logic [EXP_W-1:0]    a_e, b_e;
    logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [DATA_W-1:0]   res_d;

    assign a_e    = op_a[DATA_W-2 -: EXP_W];
    assign b_e    = op_b[DATA_W-2 -: EXP_W];
    assign a_zero = a_e == '0;
    assign b_zero = b_e == '0;
    assign a_inf  = &a_e && op_a[FRAC_W-1:0] == '0;
    assign b_inf  = &b_e && op_b[FRAC_W-1:0] == '0;
    assign a_nan  = &a_e && |op_a[FRAC_W-1:0];
    assign b_nan  = &b_e && |op_b[FRAC_W-1:0];
    assign sp_d   = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? SP_NAN :
                    (a_inf || b_inf) ? SP_INF : (a_zero || b_zero) ? SP_ZERO : SP_NONE;

    // one multiplier bit per cycle: conditional add into the upper half, then shift right
    assign add_d   = {1'b0, acc_q[2*MAN_W-1:MAN_W]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    assign acc_d   = {add_d, acc_q[MAN_W-1:1]};
    assign pn      = acc_q[2*MAN_W-1] ? acc_q : {acc_q[2*MAN_W-2:0], 1'b0};
    assign rnd_up  = g_q && (r_q || s_q || man_q[0]);
    assign man_rnd = {1'b0, man_q} + {{MAN_W{1'b0}}, rnd_up};
    assign e_d     = {2'b00, ea_q} + {2'b00, eb_q} - BIAS_X + {{(EXP_W+1){1'b0}}, exp_inc_q}
                   + {{(EXP_W+1){1'b0}}, man_rnd[MAN_W]};
    assign ovf_w   = !e_q[EXP_W+1] && e_q >= EMAX_X;
    assign unf_w   = e_q[EXP_W+1] || e_q == '0;
    assign res_d   = sp_q == SP_NAN  ? QNAN :
                     sp_q == SP_INF  ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
                     sp_q == SP_ZERO ? {sign_q, {(DATA_W-1){1'b0}}} :
                     ovf_w           ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
                     unf_w           ? {sign_q, {(DATA_W-1){1'b0}}} :
                                       {sign_q, e_q[EXP_W-1:0], man_q[FRAC_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            busy_q <= state_q != S_IDLE;
            done_q <= 1'b0;
            if (start) begin
                state_q <= S_MUL;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_MUL: begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= cnt_q == CNT_W'(MAN_W - 1) ? S_NORM : S_MUL;
                    end
                    S_NORM: state_q <= S_RND;
                    S_RND:  state_q <= S_FIN;
                    S_FIN: begin
                        res_q   <= res_d;
                        ovf_q   <= sp_q == SP_NONE && ovf_w;
                        unf_q   <= sp_q == SP_NONE && !ovf_w && unf_w;
                        exc_q   <= sp_q == SP_NAN;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // datapath registers need no reset: every operation reloads them on start
    always_ff @(posedge clk) begin
        if (start) begin
            sign_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            ea_q   <= a_e;
            eb_q   <= b_e;
            ma_q   <= {1'b1, op_a[FRAC_W-1:0]};
            acc_q  <= {{MAN_W{1'b0}}, 1'b1, op_b[FRAC_W-1:0]};
            sp_q   <= sp_d;
        end else begin
            case (state_q)
                S_MUL: acc_q <= acc_d;
                S_NORM: begin
                    man_q     <= pn[2*MAN_W-1:MAN_W];
                    g_q       <= pn[MAN_W-1];
                    r_q       <= pn[MAN_W-2];
                    s_q       <= |pn[MAN_W-3:0];
                    exp_inc_q <= acc_q[2*MAN_W-1];
                end
                S_RND: begin
                    man_q <= man_rnd[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : man_rnd[MAN_W-1:0];
                    e_q   <= e_d;
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res       = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign exception = exc_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: scoreboard bench; the stimulus side queues expected results, and a monitor pops them on done.
module tb_fp_mul_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, overflow, underflow, exception;
    logic [31:0] res;

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .op_a(op_a), .op_b(op_b), .overflow(overflow), .underflow(underflow),
        .exception(exception), .res(res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, errors = 0, checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && done) begin
            if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
                x = q.pop_front();
                chk("res", {32'd0, res}, {32'd0, x.res});
                chk("flags", {61'd0, overflow, underflow, exception}, {61'd0, x.fl});
                chk("latency", 64'(cyc), 64'(x.cyc));
            end
        end
    end

    // reference: exact integer product, nearest-even rounding by remainder vs. half
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        int     ea, eb, e, sh;
        logic   s, an, bn, ai, bi, az, bz;
        longint p, m, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        an = ea == 255 && a[22:0] != 0;
        bn = eb == 255 && b[22:0] != 0;
        ai = ea == 255 && a[22:0] == 0;
        bi = eb == 255 && b[22:0] == 0;
        az = ea == 0;
        bz = eb == 0;
        r.cyc = 0;
        r.fl  = 3'b000;
        if (an || bn || (ai && bz) || (bi && az)) begin
            r.res = 32'h7FC00000;
            r.fl  = 3'b001;
        end else if (ai || bi) r.res = {s, 8'hFF, 23'd0};
        else if (az || bz) r.res = {s, 31'd0};
        else begin
            p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            sh   = p >= (longint'(1) << 47) ? 24 : 23;
            e    = ea + eb - 127 + (sh - 23);
            m    = p >> sh;
            rem  = p - (m << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && m[0])) m++;
            if (m == (longint'(1) << 24)) begin
                m = m >> 1;
                e++;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'd0};
                r.fl  = 3'b100;
            end else if (e <= 0) begin
                r.res = {s, 31'd0};
                r.fl  = 3'b010;
            end else r.res = {s, 8'(e), m[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        e = 8'($urandom_range(100, 154));
        if (k == 0) e = 8'd0;
        else if (k == 1) begin
            e = 8'hFF;
            f = '0;
        end else if (k == 2) begin
            e = 8'hFF;
            f = f | 23'd1;
        end else if (k < 8) e = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit restart);
        @(negedge clk);
        if (restart && q.size() > 0) void'(q.pop_back());
        e.cyc = cyc + 28;
        q.push_back(e);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [2:0] fl);
        exp_t x;
        x.res = r;
        x.fl  = fl;
        x.cyc = 0;
        return x;
    endfunction

    logic [31:0] da[10] = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'hC0000000,
                            32'h7F800000, 32'h7FC00000, 32'h7F000000, 32'h00800000, 32'h80800000};
    logic [31:0] db[10] = '{32'h40200000, 32'h3FC00000, 32'h3FC00000, 32'h3F800001, 32'h7F800000,
                            32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h00400000};
    logic [31:0] dr[10] = '{32'h40F00000, 32'h40100000, 32'h3FC00002, 32'h3F800002, 32'hFF800000,
                            32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
    logic [2:0]  df[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                            3'b001, 3'b001, 3'b100, 3'b010, 3'b000};

    initial begin
        int nb;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {29'd0, busy, done, overflow, underflow, exception, res}, 64'd0);
        rst_n = 1'b1;

        do_start(da[0], db[0], mk(dr[0], df[0]), 1'b0);
        nb = 0;
        repeat (31) begin
            if (busy) nb++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(nb), 64'd27);
        wait_idle();

        for (int i = 1; i < 10; i++) begin
            do_start(da[i], db[i], mk(dr[i], df[i]), 1'b0);
            wait_idle();
        end

        do_start(32'h3F800000, 32'h40000000, mk(32'h40000000, 3'b000), 1'b0);
        repeat (8) @(negedge clk);
        do_start(32'h40400000, 32'h40200000, mk(32'h40F00000, 3'b000), 1'b1);
        wait_idle();

        do_start(32'h3F800000, 32'h40000000, mk(32'h40000000, 3'b000), 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk("async_reset", {29'd0, busy, done, overflow, underflow, exception, res}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        do_start(32'h40400000, 32'h40200000, mk(32'h40F00000, 3'b000), 1'b0);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            a = rnd_op();
            b = rnd_op();
            do_start(a, b, model(a, b), 1'b0);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Multi-cycle IEEE-754 single-format floating-point multiplier; the multiply counterpart to the sequential divider in the FPU datapath.
- The mantissa product comes from an iterative radix-2 shift-add array, one multiplier bit per cycle.
- Normalize, round-to-nearest-even and pack stages follow.
- Fixed latency with start/done handshake; special cases and overflow/underflow/exception flags are fully implemented.

Parameters:
DATA_W  32  total operand/result width
EXP_W   8   exponent width; MAN_W = DATA_W-EXP_W (mantissa incl. hidden bit), BIAS = 2**(EXP_W-1)-1

Ports:
clk        input   1       clock, all logic on rising edge
rst_n      input   1       asynchronous active-low reset
start      input   1       one-cycle request; operands sampled on this edge
busy       output  1       high while an operation is in flight
done       output  1       one-cycle pulse, res/flags valid
op_a       input   DATA_W  multiplicand
op_b       input   DATA_W  multiplier
overflow   output  1       result exceeded max finite, res = signed Inf
underflow  output  1       result below min normal, res = signed zero
exception  output  1       invalid operation (Inf*0, NaN operand)
res        output  DATA_W  packed result

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, busy=0, done=0, res=0, overflow=underflow=exception=0. Reset mid-operation aborts; no done is produced.
- Latency: start high at edge k -> done high for exactly one cycle after edge k+L, L = MAN_W+3 (27 for default).
- States:
  - IDLE: on start, register sign = a_s^b_s, exponents, mantissas {1,frac}; classify specials; go to MUL; counter=0.
  - MUL: MAN_W cycles; each cycle, if multiplier LSB set, add multiplicand to upper half of 2*MAN_W accumulator; shift right. When counter==MAN_W-1, go to NORM.
  - NORM: 1 cycle. If product[2*MAN_W-1]=1, take the upper MAN_W bits and set exp_inc=1; else shift left by 1. Guard = next bit, round = bit after, sticky = OR of the rest.
  - RND: 1 cycle. Signed exponent e = ea+eb-BIAS+exp_inc in EXP_W+2 bits. RNE: increment when guard & (round|sticky|lsb). A mantissa carry-out sets the mantissa to 1.0 and e+1.
  - DONE: register res/flags, pulse done, go to IDLE.
- busy: high from the edge after start through the done cycle inclusive.
- Range checks, applied after rounding:
  - e >= 2**EXP_W-1: res = {sign, all-ones exp, 0}, overflow=1.
  - e <= 0: res = {sign, 0}, underflow=1. Subnormal outputs are not produced.
- Special cases (exponent 0 inputs are flushed to zero; latency stays L):
  - Any NaN operand: res = quiet NaN {0, all-ones exp, 1, 0...}, exception=1.
  - Inf*0: quiet NaN, exception=1.
  - Inf*finite-nonzero or Inf*Inf: signed Inf, no flags.
  - Zero*finite: signed zero, no flags.
- res and flags hold until the next done.
- Start while busy: abort the current operation and restart with the new operands at that edge. Only one done is produced, L after the latest start.

Test Plan:
- 0x40400000 * 0x40200000 (3.0*2.5): done exactly 27 cycles after start; res=0x40F00000; flags 0; busy high for 27 cycles.
- 0x3FC00000 * 0x3FC00000 (product-MSB normalize path): res=0x40100000. Then 0x3F800001 * 0x3FC00000 (RNE tie): res=0x3FC00002. Then 0x3F800001 * 0x3F800001 (below half): res=0x3F800002.
- 0xC0000000 * 0x7F800000: res=0xFF800000, flags 0. 0x7F800000 * 0x00000000: res=0x7FC00000, exception=1. 0x7FC00000 * 0x3F800000: res=0x7FC00000, exception=1.
- 0x7F000000 * 0x40000000: res=0x7F800000, overflow=1. 0x00800000 * 0x3F000000: res=0x00000000, underflow=1. 0x80800000 * 0x00400000 (subnormal flush): res=0x80000000, no flags.
- start (1.0*2.0) at cycle 0, start (3.0*2.5) at cycle 10: single done at cycle 37, res=0x40F00000.
- rst_n pulled low at cycle 5 of an operation: all outputs 0 immediately; no done; a new start after release completes normally.
